// File: rtl/seq_detector_pkg.sv
// Shared definitions for the serial pattern detector.
// Holds the width helper, the S0 encoding and the elaboration-time next-state table builder.
// The detector indexes the table by {state, bit}, so no search logic is built in hardware.
package seq_detector_pkg;

  localparam int unsigned MaxLen = 16;
  // Table entries are wide enough for any prefix length up to MaxLen.
  localparam int unsigned StW    = 5;
  localparam int unsigned TblW   = 2 * MaxLen * StW;

  localparam logic [StW-1:0] S0 = '0;

  // Number of bits needed to hold the values 0..n.
  function automatic int unsigned width_of(input int unsigned n);
    int unsigned w;
    w = 1;
    for (int i = 1; i < 32; i++) begin
      if ((n >> i) != 0) w = i + 1;
    end
    return w;
  endfunction

  // Longest proper prefix of pat that is a suffix of (first k pattern bits, then b).
  // The prefix length is capped at len-1, so after a full match this gives the overlap
  // restart point f. pat[len-1] is the first bit received.
  function automatic logic [StW-1:0] next_len(input logic [MaxLen-1:0] pat,
                                              input int unsigned     len,
                                              input int unsigned     k,
                                              input logic            b);
    logic [MaxLen-1:0] s;
    int unsigned       best;
    int unsigned       lim;
    logic              ok;
    s = '0;
    for (int i = 0; i < MaxLen; i++) begin
      if (i < k) s[i] = pat[len-1-i];
    end
    s[k] = b;
    best = 0;
    lim  = (k + 1 < len) ? k + 1 : len - 1;
    for (int j = 1; j <= MaxLen; j++) begin
      if (j <= lim) begin
        ok = 1'b1;
        for (int m = 0; m < MaxLen; m++) begin
          if (m < j && pat[len-1-m] != s[k+1-j+m]) ok = 1'b0;
        end
        if (ok) best = j;
      end
    end
    return StW'(best);
  endfunction

  // Packed table, entry (2*k + b) holds the next state from Sk on bit b.
  function automatic logic [TblW-1:0] build_table(input logic [MaxLen-1:0] pat,
                                                  input int unsigned     len);
    logic [TblW-1:0] t;
    t = '0;
    for (int k = 0; k < MaxLen; k++) begin
      for (int b = 0; b < 2; b++) begin
        if (k < len) t[(2*k+b)*StW +: StW] = next_len(pat, len, k, b[0]);
      end
    end
    return t;
  endfunction

endpackage

// File: rtl/seq_match_counter.sv
// Saturating match counter.
// Ports: clk_synthetic/rst (async active-low) clock and reset, clr_i synchronous clear
// (wins over inc_i), inc_i count enable, cnt_o current count (sticks at all-ones).
module seq_match_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk_synthetic,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_synthetic or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/seq_detector.sv
// Parametrised serial pattern detector (Mealy-style prefix FSM with failure links).
// Ports: clk_synthetic divided clock; rst async active-low reset; in_valid qualifies in;
// in serial bit (PATTERN[LEN-1] first); overlap selects overlapping matches; clr sync clear;
// match registered one-cycle pulse; progress matched prefix length; match_cnt saturating
// match count; seen sticky match flag.
// Build option: SEQ_DET_STICKY_EN enables the sticky seen flag, otherwise seen is tied to 0.
module seq_detector
  import seq_detector_pkg::*;
#(
  parameter int unsigned    LEN     = 4,
  parameter logic [LEN-1:0] PATTERN = 4'b1011,
  parameter int unsigned    CNT_W   = 8,
  localparam int unsigned   PW      = width_of(LEN)
) (
  input  logic             clk_synthetic,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in,
  input  logic             overlap,
  input  logic             clr,
  output logic             match,
  output logic [PW-1:0]    progress,
  output logic [CNT_W-1:0] match_cnt,
  output logic             seen
);

  localparam logic [MaxLen-1:0] PatExt = MaxLen'(PATTERN);
  localparam logic [TblW-1:0]   NxtTbl = build_table(PatExt, LEN);
  localparam logic [PW-1:0]     SLast  = PW'(LEN - 1);

  logic [PW-1:0]  state_d, state_q;
  logic           match_d, match_q;
  logic [StW:0]   tbl_idx;
  logic [StW-1:0] tbl_nxt;
  logic           hit;

  always_comb begin
    tbl_idx = {StW'(state_q), in};
    tbl_nxt = NxtTbl[tbl_idx*StW +: StW];
    hit     = in_valid && (state_q == SLast) && (in == PatExt[0]);

    state_d = state_q;
    match_d = 1'b0;
    if (clr) begin
      state_d = PW'(S0);
    end else if (in_valid) begin
      match_d = hit;
      if (hit && !overlap) state_d = PW'(S0);
      else                 state_d = PW'(tbl_nxt);
    end
  end

  always_ff @(posedge clk_synthetic or negedge rst) begin
    if (!rst) begin
      state_q <= PW'(S0);
      match_q <= 1'b0;
    end else begin
      state_q <= state_d;
      match_q <= match_d;
    end
  end

  seq_match_counter #(
    .W (CNT_W)
  ) u_cnt (
    .clk_synthetic (clk_synthetic),
    .rst           (rst),
    .clr_i         (clr),
    .inc_i         (match_d),
    .cnt_o         (match_cnt)
  );

`ifdef SEQ_DET_STICKY_EN
  logic seen_d, seen_q;

  always_comb begin
    seen_d = seen_q | match_d;
    if (clr) seen_d = 1'b0;
  end

  always_ff @(posedge clk_synthetic or negedge rst) begin
    if (!rst) seen_q <= 1'b0;
    else      seen_q <= seen_d;
  end

  assign seen = seen_q;
`else
  assign seen = 1'b0;
`endif

  assign match    = match_q;
  assign progress = state_q;

endmodule

// File: tb/tb_seq_detector.sv
module tb_seq_detector;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_bit;
  logic       overlap;
  logic       clr;
  logic       match, match2;
  logic [2:0] progress, progress2;
  logic [7:0] match_cnt;
  logic [1:0] match_cnt2;
  logic       seen, seen2;

  int checks;
  int failures;

`ifdef SEQ_DET_STICKY_EN
  localparam logic StickyOn = 1'b1;
`else
  localparam logic StickyOn = 1'b0;
`endif

  seq_detector #(.LEN(4), .PATTERN(4'b1011), .CNT_W(8)) dut (
    .clk_synthetic (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in            (in_bit),
    .overlap       (overlap),
    .clr           (clr),
    .match         (match),
    .progress      (progress),
    .match_cnt     (match_cnt),
    .seen          (seen)
  );

  seq_detector #(.LEN(4), .PATTERN(4'b1011), .CNT_W(2)) dut2 (
    .clk_synthetic (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in            (in_bit),
    .overlap       (overlap),
    .clr           (clr),
    .match         (match2),
    .progress      (progress2),
    .match_cnt     (match_cnt2),
    .seen          (seen2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply inputs, take one rising edge, settle 1ns past it.
  task automatic drive(input logic v, input logic b, input logic c);
    in_valid = v;
    in_bit   = b;
    clr      = c;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; in_valid = 1'b1; in_bit = 1'b1; overlap = 1'b1; clr = 1'b0;
    #12;
    checks++;
    if (match !== 1'b0 || progress !== 3'd0 || match_cnt !== 8'd0 || seen !== 1'b0) begin
      failures++;
      $display("FAIL reset: match=%b progress=%0d cnt=%0d seen=%b required 0/0/0/0",
               match, progress, match_cnt, seen);
    end
    #2 rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0);
    checks++;
    if (progress !== 3'd0) begin
      failures++;
      $display("FAIL reset_hold: progress=%0d required 0", progress);
    end
  endtask

  task automatic test_overlap();
    logic [6:0] bits;
    logic [6:0] exp_m;
    int         exp_p[7];
    bits  = 7'b1011011;
    exp_m = 7'b0001001;
    exp_p = '{1, 2, 3, 1, 2, 3, 1};
    overlap = 1'b1;
    drive(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, bits[6-i], 1'b0);
      checks++;
      if (match !== exp_m[6-i] || progress !== 3'(exp_p[i])) begin
        failures++;
        $display("FAIL overlap bit%0d: match=%b progress=%0d required %b/%0d",
                 i + 1, match, progress, exp_m[6-i], exp_p[i]);
      end
    end
    checks++;
    if (match_cnt !== 8'd2) begin
      failures++;
      $display("FAIL overlap_cnt: cnt=%0d required 2", match_cnt);
    end
  endtask

  task automatic test_no_overlap();
    logic [6:0] bits;
    logic [6:0] exp_m;
    int         exp_p[7];
    bits  = 7'b1011011;
    exp_m = 7'b0001000;
    exp_p = '{1, 2, 3, 0, 0, 1, 1};
    overlap = 1'b0;
    drive(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, bits[6-i], 1'b0);
      checks++;
      if (match !== exp_m[6-i] || progress !== 3'(exp_p[i])) begin
        failures++;
        $display("FAIL no_overlap bit%0d: match=%b progress=%0d required %b/%0d",
                 i + 1, match, progress, exp_m[6-i], exp_p[i]);
      end
    end
    checks++;
    if (match_cnt !== 8'd1) begin
      failures++;
      $display("FAIL no_overlap_cnt: cnt=%0d required 1", match_cnt);
    end
  endtask

  task automatic test_gaps();
    logic [3:0] bits;
    logic [3:0] exp_m;
    int         exp_p[4];
    bits  = 4'b1011;
    exp_m = 4'b0001;
    exp_p = '{1, 2, 3, 0};
    overlap = 1'b0;
    drive(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, bits[3-i], 1'b0);
      checks++;
      if (match !== exp_m[3-i] || progress !== 3'(exp_p[i])) begin
        failures++;
        $display("FAIL gaps bit%0d: match=%b progress=%0d required %b/%0d",
                 i + 1, match, progress, exp_m[3-i], exp_p[i]);
      end
      // Idle cycle with a misleading data value: nothing may move.
      drive(1'b0, ~bits[3-i], 1'b0);
      checks++;
      if (match !== 1'b0 || progress !== 3'(exp_p[i])) begin
        failures++;
        $display("FAIL gaps idle%0d: match=%b progress=%0d required 0/%0d",
                 i + 1, match, progress, exp_p[i]);
      end
    end
    checks++;
    if (match_cnt !== 8'd1) begin
      failures++;
      $display("FAIL gaps_cnt: cnt=%0d required 1", match_cnt);
    end
  endtask

  task automatic test_saturate();
    logic [3:0] bits;
    logic [1:0] exp_c[5];
    bits  = 4'b1011;
    exp_c = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    overlap = 1'b0;
    drive(1'b0, 1'b0, 1'b1);
    for (int r = 0; r < 5; r++) begin
      for (int i = 0; i < 4; i++) drive(1'b1, bits[3-i], 1'b0);
      checks++;
      if (match2 !== 1'b1 || match_cnt2 !== exp_c[r]) begin
        failures++;
        $display("FAIL saturate rep%0d: match=%b cnt=%0d required 1/%0d",
                 r + 1, match2, match_cnt2, exp_c[r]);
      end
    end
    checks++;
    if (match_cnt !== 8'd5) begin
      failures++;
      $display("FAIL saturate_wide_cnt: cnt=%0d required 5", match_cnt);
    end
  endtask

  task automatic test_clr();
    logic [3:0] bits;
    bits = 4'b1011;
    overlap = 1'b0;
    drive(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) drive(1'b1, bits[3-i], 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b1, bits[3-i], 1'b0);
    checks++;
    if (match_cnt !== 8'd1 || progress !== 3'd3 || seen !== StickyOn) begin
      failures++;
      $display("FAIL clr_pre: cnt=%0d progress=%0d seen=%b required 1/3/%b",
               match_cnt, progress, seen, StickyOn);
    end
    drive(1'b1, 1'b1, 1'b1);
    checks++;
    if (match !== 1'b0 || match_cnt !== 8'd0 || progress !== 3'd0 || seen !== 1'b0) begin
      failures++;
      $display("FAIL clr: match=%b cnt=%0d progress=%0d seen=%b required 0/0/0/0",
               match, match_cnt, progress, seen);
    end
    drive(1'b0, 1'b0, 1'b0);
    checks++;
    if (match !== 1'b0) begin
      failures++;
      $display("FAIL clr_after: match=%b required 0", match);
    end
  endtask

  task automatic test_async_reset();
    logic [3:0] bits;
    bits = 4'b1011;
    overlap = 1'b0;
    drive(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) drive(1'b1, bits[3-i], 1'b0);
    in_valid = 1'b0;
    checks++;
    if (progress !== 3'd3) begin
      failures++;
      $display("FAIL rst_pre: progress=%0d required 3", progress);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (progress !== 3'd0 || match !== 1'b0) begin
      failures++;
      $display("FAIL rst_async: progress=%0d match=%b required 0/0", progress, match);
    end
    rst = 1'b1;
    drive(1'b1, 1'b1, 1'b0);
    checks++;
    if (match !== 1'b0 || progress !== 3'd1) begin
      failures++;
      $display("FAIL rst_after: match=%b progress=%0d required 0/1", match, progress);
    end
  endtask

  task automatic test_sticky();
    logic [3:0] bits;
    bits = 4'b1011;
    overlap = 1'b1;
    drive(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) drive(1'b1, bits[3-i], 1'b0);
    checks++;
    if (seen !== StickyOn || match !== 1'b1) begin
      failures++;
      $display("FAIL sticky_set: seen=%b match=%b required %b/1", seen, match, StickyOn);
    end
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    checks++;
    if (seen !== StickyOn) begin
      failures++;
      $display("FAIL sticky_hold: seen=%b required %b", seen, StickyOn);
    end
    drive(1'b0, 1'b0, 1'b1);
    checks++;
    if (seen !== 1'b0) begin
      failures++;
      $display("FAIL sticky_clr: seen=%b required 0", seen);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_overlap();
    test_no_overlap();
    test_gaps();
    test_saturate();
    test_clr();
    test_async_reset();
    test_sticky();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
